// File: rtl/clock_pkg.sv
// Shared constants and helpers for the wall-clock minute/hour stages.
// Holds field widths, wrap limits and the debounce counter sizing.
package clock_pkg;

    localparam int MINUTE_W = 6;
    localparam int HOUR_W   = 5;

    localparam logic [MINUTE_W-1:0] MINUTE_MAX = 6'd59;
    localparam logic [HOUR_W-1:0]   HOUR_MAX   = 5'd23;

    localparam int DEBOUNCE_CYCLES_DFLT = 1_000_000;

    // Counter only has to reach cycles-1, so ceil(log2(cycles)) bits suffice.
    function automatic int debounce_w(int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

    localparam int DEBOUNCE_W = debounce_w(DEBOUNCE_CYCLES_DFLT);

    function automatic logic [6:0] bin2bcd(logic [MINUTE_W-1:0] v);
        logic [2:0]          t;
        logic [MINUTE_W-1:0] r;
        t = '0;
        r = v;
        for (int i = 0; i < 5; i++) begin
            if (r >= 6'd10) begin
                r = r - 6'd10;
                t = t + 3'd1;
            end
        end
        return {t, 4'(r)};
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop sync, stability counter, debounced
// level and a registered one-cycle pulse on each accepted press.
module key_debounce
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_i,
    output logic press_o
);

    localparam int CW = debounce_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q;

    // Any return to the accepted level drops the count back to zero.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q[1] != level_q) begin
            if (cnt_q == LAST) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], key_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= level_d & ~level_q;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/minute_counter.sv
// Minute stage: 0..59 counter with carry in/out and debounced Add/Subtract.
// Define MINUTE_BCD_EN to add registered bcd_tens/bcd_units outputs.
module minute_counter
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT
) (
    input  logic                Clk_50MHz,
    input  logic                Reset_N,
    input  logic                Sixty_in,
    input  logic                Add,
    input  logic                Subtract,
    output logic                Sixty_out,
    output logic [MINUTE_W-1:0] count
`ifdef MINUTE_BCD_EN
    ,
    output logic [2:0]          bcd_tens,
    output logic [3:0]          bcd_units
`endif
);

    logic add_p, sub_p;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_add (
        .clk_i   (Clk_50MHz),
        .rst_ni  (Reset_N),
        .key_i   (Add),
        .press_o (add_p)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sub (
        .clk_i   (Clk_50MHz),
        .rst_ni  (Reset_N),
        .key_i   (Subtract),
        .press_o (sub_p)
    );

    logic [MINUTE_W-1:0] count_q, count_d;
    logic [MINUTE_W-1:0] inc, dec;
    logic                pending_q, pending_d;
    logic                carry_q, carry_d;
    logic                tick, adj;

    assign inc  = (count_q == MINUTE_MAX) ? '0 : count_q + 6'd1;
    assign dec  = (count_q == '0) ? MINUTE_MAX : count_q - 6'd1;
    assign tick = Sixty_in | pending_q;
    assign adj  = add_p | sub_p;

    // An adjustment always wins the cycle; a coincident tick waits one cycle.
    always_comb begin
        count_d   = count_q;
        pending_d = pending_q;
        carry_d   = 1'b0;
        if (adj) begin
            pending_d = tick;
            if (add_p && !sub_p) begin
                count_d = inc;
            end else if (sub_p && !add_p) begin
                count_d = dec;
            end
        end else if (tick) begin
            pending_d = 1'b0;
            count_d   = inc;
            carry_d   = (count_q == MINUTE_MAX);
        end
    end

    always_ff @(posedge Clk_50MHz or negedge Reset_N) begin
        if (!Reset_N) begin
            count_q   <= '0;
            pending_q <= 1'b0;
            carry_q   <= 1'b0;
        end else begin
            count_q   <= count_d;
            pending_q <= pending_d;
            carry_q   <= carry_d;
        end
    end

    assign count     = count_q;
    assign Sixty_out = carry_q;

`ifdef MINUTE_BCD_EN
    logic [6:0] bcd_q;

    always_ff @(posedge Clk_50MHz or negedge Reset_N) begin
        if (!Reset_N) begin
            bcd_q <= '0;
        end else begin
            bcd_q <= bin2bcd(count_d);
        end
    end

    assign bcd_tens  = bcd_q[6:4];
    assign bcd_units = bcd_q[3:0];
`endif

endmodule

// File: tb/tb_minute_counter.sv
// Directed bench for minute_counter with a 4-cycle debounce window.
module tb_minute_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sixty_in;
    logic       add;
    logic       sub;
    logic       sixty_out;
    logic [5:0] count;
`ifdef MINUTE_BCD_EN
    logic [2:0] bcd_tens;
    logic [3:0] bcd_units;
`endif

    int checks = 0;
    int errors = 0;
    int seen;

    minute_counter #(.DEBOUNCE_CYCLES(4)) dut (
        .Clk_50MHz (clk),
        .Reset_N   (rst_n),
        .Sixty_in  (sixty_in),
        .Add       (add),
        .Subtract  (sub),
        .Sixty_out (sixty_out),
        .count     (count)
`ifdef MINUTE_BCD_EN
        ,
        .bcd_tens  (bcd_tens),
        .bcd_units (bcd_units)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_count(input string tag, input int exp);
        chk(tag, 32'(count), exp);
`ifdef MINUTE_BCD_EN
        chk({tag, "_tens"}, 32'(bcd_tens), exp / 10);
        chk({tag, "_units"}, 32'(bcd_units), exp % 10);
`endif
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick();
        sixty_in = 1'b1;
        @(negedge clk);
        sixty_in = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        sixty_in = 1'b0;
        add      = 1'b0;
        sub      = 1'b0;
        cycles(2);
        check_count("reset_count", 0);
        chk("reset_sixty", 32'(sixty_out), 0);
        rst_n = 1'b1;
        cycles(1);

        seen = 0;
        for (int i = 0; i < 59; i++) begin
            tick();
            if (sixty_out) seen = 1;
        end
        chk("no_carry_below_59", seen, 0);
        check_count("count_59", 59);
        tick();
        check_count("wrap_0", 0);
        chk("carry_pulse", 32'(sixty_out), 1);
        cycles(1);
        chk("carry_one_cycle", 32'(sixty_out), 0);

        sub = 1'b1;
        cycles(6);
        check_count("sub_before_latency", 0);
        cycles(1);
        check_count("sub_wrap_59", 59);
        chk("sub_no_carry", 32'(sixty_out), 0);
        cycles(10);
        check_count("sub_held_no_repeat", 59);
        sub = 1'b0;
        cycles(10);
        check_count("sub_release", 59);

        add = 1'b1;
        cycles(7);
        check_count("add_wrap_0", 0);
        chk("add_no_carry", 32'(sixty_out), 0);
        cycles(1);
        chk("add_no_carry_late", 32'(sixty_out), 0);
        add = 1'b0;
        cycles(10);

        for (int i = 0; i < 5; i++) begin
            add = 1'b1;
            cycles(2);
            add = 1'b0;
            cycles(2);
        end
        check_count("bounce_ignored", 0);
        add = 1'b1;
        cycles(50);
        check_count("bounce_one_inc", 1);
        add = 1'b0;
        cycles(10);
        check_count("bounce_release", 1);

        repeat (58) tick();
        check_count("pre_pending_59", 59);
        add = 1'b1;
        cycles(6);
        sixty_in = 1'b1;
        cycles(1);
        sixty_in = 1'b0;
        check_count("adj_with_tick_N", 0);
        chk("adj_with_tick_no_carry", 32'(sixty_out), 0);
        cycles(1);
        check_count("pending_N1", 1);
        chk("pending_no_carry", 32'(sixty_out), 0);
        cycles(1);
        check_count("pending_cleared", 1);
        add = 1'b0;
        cycles(10);

        repeat (29) tick();
        check_count("pre_double_30", 30);
        add = 1'b1;
        sub = 1'b1;
        cycles(7);
        check_count("double_press_hold", 30);
        cycles(5);
        check_count("double_press_later", 30);
        add = 1'b0;
        sub = 1'b0;
        cycles(10);
        check_count("double_release", 30);

        repeat (12) tick();
        check_count("pre_reset_42", 42);
        add = 1'b1;
        cycles(3);
        rst_n = 1'b0;
        add   = 1'b0;
        #1;
        check_count("async_reset", 0);
        chk("async_reset_sixty", 32'(sixty_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(15);
        check_count("no_stale_press", 0);
        add = 1'b1;
        cycles(7);
        check_count("fresh_press", 1);
        add = 1'b0;
        cycles(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
